// File: rtl/shift_sequencer_if.sv
// Command / result handshake bundle between a command source and shift_sequencer.
// The source side uses the master modport and the sequencer uses the slave modport.
interface shift_sequencer_if #(
   parameter int AMT_W = 5
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_rotate;
   logic             cmd_dir;
   logic [AMT_W-1:0] cmd_amount;
   logic [3:0]       cmd_data;
   logic             res_valid;
   logic             res_ready;
   logic [3:0]       res_data;
   logic [2:0]       res_passes;

   modport master (
      output cmd_valid, cmd_rotate, cmd_dir, cmd_amount, cmd_data, res_ready,
      input  cmd_ready, res_valid, res_data, res_passes
   );

   modport slave (
      input  cmd_valid, cmd_rotate, cmd_dir, cmd_amount, cmd_data, res_ready,
      output cmd_ready, res_valid, res_data, res_passes
   );
endinterface

// File: rtl/shift_sequencer.sv
// Drives an external 4-bit barrel shifter (0..3 positions per pass) over several
// passes to perform a shift or rotate by any amount.
module shift_sequencer #(
   parameter int AMT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_sequencer_if.slave     bus,
   output logic                 busy,
   output logic                 sh_select,
   output logic                 sh_direction,
   output logic [1:0]           sh_shift_value,
   output logic [3:0]           sh_din,
   input  logic [3:0]           sh_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_r;
   logic [3:0] data_r;
   logic [2:0] rem_r;
   logic [2:0] passes_r;
   logic       rot_r;
   logic       dir_r;
   logic [1:0] step_r;
   logic       cmd_ready_r;
   logic       res_valid_r;
   logic       busy_r;
   logic [3:0] res_data_r;
   logic [2:0] res_passes_r;

   logic [2:0] eff_s;
   logic [2:0] rem_next_s;

   // Rotates wrap every 4 positions; shifts of 4 or more leave an all-zero word.
   function automatic logic [2:0] eff_amount(input logic rotate, input logic [AMT_W-1:0] amount);
      logic [2:0] eff;
      if (rotate) begin
         eff = {1'b0, amount[1:0]};
      end else if (amount > AMT_W'(3)) begin
         eff = 3'd4;
      end else begin
         eff = amount[2:0];
      end
      return eff;
   endfunction

   function automatic logic [1:0] pass_step(input logic [2:0] rem);
      logic [1:0] step;
      if (rem > 3'd3) begin
         step = 2'd3;
      end else begin
         step = rem[1:0];
      end
      return step;
   endfunction

   // Effective amount of the offered command and remaining distance after this pass.
   always_comb begin
      eff_s      = eff_amount(bus.cmd_rotate, bus.cmd_amount);
      rem_next_s = rem_r - {1'b0, step_r};
   end

   // Sequencer FSM; step_r is preloaded so the shift amount is already stable in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         data_r       <= 4'd0;
         rem_r        <= 3'd0;
         passes_r     <= 3'd0;
         rot_r        <= 1'b0;
         dir_r        <= 1'b0;
         step_r       <= 2'd0;
         cmd_ready_r  <= 1'b1;
         res_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         res_data_r   <= 4'd0;
         res_passes_r <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.cmd_valid) begin
                  data_r      <= bus.cmd_data;
                  rot_r       <= bus.cmd_rotate;
                  dir_r       <= bus.cmd_dir;
                  passes_r    <= 3'd0;
                  rem_r       <= eff_s;
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  if (eff_s == 3'd0) begin
                     state_r      <= DONE;
                     step_r       <= 2'd0;
                     res_valid_r  <= 1'b1;
                     res_data_r   <= bus.cmd_data;
                     res_passes_r <= 3'd0;
                  end else begin
                     state_r <= RUN;
                     step_r  <= pass_step(eff_s);
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               data_r   <= sh_dout;
               rem_r    <= rem_next_s;
               passes_r <= passes_r + 3'd1;
               if (rem_next_s == 3'd0) begin
                  state_r      <= DONE;
                  step_r       <= 2'd0;
                  res_valid_r  <= 1'b1;
                  res_data_r   <= sh_dout;
                  res_passes_r <= passes_r + 3'd1;
               end else begin
                  state_r <= RUN;
                  step_r  <= pass_step(rem_next_s);
               end
            end
            DONE: begin
               if (bus.res_ready) begin
                  state_r     <= IDLE;
                  res_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               step_r      <= 2'd0;
               res_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = cmd_ready_r;
   assign bus.res_valid  = res_valid_r;
   assign bus.res_data   = res_data_r;
   assign bus.res_passes = res_passes_r;
   assign busy           = busy_r;
   assign sh_select      = rot_r;
   assign sh_direction   = dir_r;
   assign sh_shift_value = step_r;
   assign sh_din         = data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural 4-bit barrel shifter
// closing the sh_* loop.
module tb_shift_sequencer;
   localparam int AMT_W = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic       sh_select;
   logic       sh_direction;
   logic [1:0] sh_shift_value;
   logic [3:0] sh_din;
   logic [3:0] sh_dout;

   shift_sequencer_if #(.AMT_W(AMT_W)) bus ();

   shift_sequencer #(.AMT_W(AMT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .busy           (busy),
      .sh_select      (sh_select),
      .sh_direction   (sh_direction),
      .sh_shift_value (sh_shift_value),
      .sh_din         (sh_din),
      .sh_dout        (sh_dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] data;
      logic [2:0] passes;
      int         lat;
      int         acc;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   bit         seen    = 1'b0;
   logic [5:0] sv_log  = 6'd0;

   function automatic logic [3:0] step1(input logic [3:0] d, input logic rot, input logic dir);
      if (dir) return rot ? {d[2:0], d[3]} : {d[2:0], 1'b0};
      else     return rot ? {d[0], d[3:1]} : {1'b0, d[3:1]};
   endfunction

   function automatic logic [3:0] move(input logic [3:0] d, input logic rot, input logic dir, input int n);
      logic [3:0] r;
      r = d;
      for (int i = 0; i < n; i++) r = step1(r, rot, dir);
      return r;
   endfunction

   always_comb sh_dout = move(sh_din, sh_select, sh_direction, int'(sh_shift_value));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: check results against the queue head and push a prediction on each accept.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         seen = 1'b0;
      end else begin
         if (bus.res_valid && !seen) begin
            seen = 1'b1;
            check("result_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
         end
         if (bus.res_valid && bus.res_ready && sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("res_data", bus.res_data, mon_e.data);
            check("res_passes", bus.res_passes, mon_e.passes);
            seen = 1'b0;
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            int a, eff;
            a   = int'(bus.cmd_amount);
            eff = bus.cmd_rotate ? (a % 4) : ((a >= 4) ? 4 : a);
            mon_e.data   = move(bus.cmd_data, bus.cmd_rotate, bus.cmd_dir, a);
            mon_e.passes = (eff == 0) ? 3'd0 : ((eff == 4) ? 3'd2 : 3'd1);
            mon_e.lat    = int'(mon_e.passes) + 1;
            mon_e.acc    = cyc + 1;
            sb_q.push_back(mon_e);
         end
         if (busy && sh_shift_value != 2'd0) sv_log = {sv_log[3:0], sh_shift_value};
      end
   end

   task automatic drive(input logic rot, input logic dir, input logic [AMT_W-1:0] amt, input logic [3:0] d);
      bus.cmd_rotate = rot;
      bus.cmd_dir    = dir;
      bus.cmd_amount = amt;
      bus.cmd_data   = d;
      bus.cmd_valid  = 1'b1;
   endtask

   task automatic wait_accept(input bit keep);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.cmd_ready && !rst) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!keep) bus.cmd_valid = 1'b0;
      check("accept_in_time", 32'(ok), 32'd1);
   endtask

   task automatic send(input logic rot, input logic dir, input logic [AMT_W-1:0] amt,
                       input logic [3:0] d, input bit keep);
      drive(rot, dir, amt, d);
      wait_accept(keep);
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_in_time", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
      check({tag, "_res_valid"}, bus.res_valid, 1'b0);
      check({tag, "_res_data"}, bus.res_data, 4'd0);
      check({tag, "_res_passes"}, bus.res_passes, 3'd0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_sh_ctl"}, {sh_select, sh_direction, sh_shift_value}, 4'd0);
      check({tag, "_sh_din"}, sh_din, 4'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   // Directed scenarios followed by a short random run.
   initial begin
      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_rotate = 1'b0;
      bus.cmd_dir    = 1'b0;
      bus.cmd_amount = '0;
      bus.cmd_data   = 4'd0;
      bus.res_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      send(1'b1, 1'b1, 5'd1, 4'b1001, 1'b0);
      wait_drain();

      sv_log = 6'd0;
      send(1'b0, 1'b0, 5'd5, 4'b1111, 1'b0);
      wait_drain();
      check("pass_sequence", sv_log, 6'b001101);

      send(1'b1, 1'b0, 5'd6, 4'b1000, 1'b0);
      wait_drain();
      send(1'b1, 1'b1, 5'd4, 4'b0110, 1'b0);
      wait_drain();

      // Hold the result back and offer a competing command meanwhile.
      bus.res_ready = 1'b0;
      send(1'b0, 1'b1, 5'd3, 4'b0001, 1'b0);
      drive(1'b1, 1'b0, 5'd1, 4'b0011);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_res_valid", bus.res_valid, 1'b1);
         check("hold_res_data", bus.res_data, 4'b1000);
         check("hold_cmd_ready", bus.cmd_ready, 1'b0);
         check("hold_busy", busy, 1'b1);
      end
      bus.res_ready = 1'b1;
      wait_accept(1'b0);
      wait_drain();

      // Reset during the first RUN cycle discards the command.
      send(1'b0, 1'b0, 5'd4, 4'b1010, 1'b0);
      check("run_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrun_reset");
      repeat (2) begin
         @(negedge clk);
         check("midrun_no_result", bus.res_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(1'b1, 1'b0, 5'd1, 4'b0001, 1'b0);
      wait_drain();

      // cmd_valid stays high across three commands.
      send(1'b1, 1'b1, 5'd2, 4'b0101, 1'b1);
      send(1'b0, 1'b0, 5'd2, 4'b1100, 1'b1);
      send(1'b1, 1'b0, 5'd7, 4'b0110, 1'b0);
      wait_drain();

      for (int i = 0; i < 12; i++) begin
         bus.res_ready = 1'($urandom_range(1, 0));
         send(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              5'($urandom_range(31, 0)), 4'($urandom_range(15, 0)), 1'b0);
         bus.res_ready = 1'b1;
         wait_drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
